mem_responder: RTL and testbench

- Unified instruction/data memory for the multi-cycle core. It sits on the memory side of the address/write-data bus that the controller and datapath drive.
- Accepts one word request at a time through a valid/ready handshake. Inserts LATENCY wait cycles, then returns a one-cycle response with read data or an error flag.
- Lets the core's FSM stall on memory instead of assuming single-cycle access.

---
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Unified instruction/data memory with a valid/ready request port and a fixed-latency,
// single-cycle response pulse carrying read data or an error flag.
module mem_responder #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned LATENCY   = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  state
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [3:0]  LatM1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            mem_we;
    logic            req_err;

    logic [31:0]     mem [DEPTH];

    assign req_err = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= DEPTH);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        rsp_err_d = rsp_err_q;
        mem_we    = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StWait;
                    cnt_d   = LatM1;
                    we_d    = req_we;
                    idx_d   = req_addr[AW+1:2];
                    wdata_d = req_wdata;
                    err_d   = req_err;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    // Commit the write here so a following read never needs forwarding.
                    state_d   = StResp;
                    rsp_err_d = err_q;
                    rdata_d   = (!err_q && !we_q) ? mem[idx_q] : 32'h0;
                    mem_we    = we_q && !err_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 32'h0;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Storage is deliberately not reset; mem_we is only ever high out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder: a timestamp-based reference model is
// compared against the DUT every cycle, plus directed literal checks and latency-variant probes.
module tb_mem_responder;

    localparam int  DEPTH  = 64;
    localparam int  LAT    = 2;
    localparam time PERIOD = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  state;

    logic        x_valid = 1'b0;
    logic [31:0] x_addr = 32'h0;
    logic        a1_ready, a1_valid, a1_err, a15_ready, a15_valid, a15_err;
    logic [31:0] a1_rdata, a15_rdata;
    logic [1:0]  a1_state, a15_state;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #(PERIOD / 2) clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .state(state)
    );

    mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .req_valid(x_valid), .req_we(1'b1),
        .req_addr(x_addr), .req_wdata(32'hCAFE0001), .req_ready(a1_ready),
        .rsp_valid(a1_valid), .rsp_rdata(a1_rdata), .rsp_err(a1_err), .state(a1_state)
    );

    mem_responder #(.DEPTH(DEPTH), .LATENCY(15)) dut_l15 (
        .clk(clk), .reset(reset), .req_valid(x_valid), .req_we(1'b1),
        .req_addr(x_addr), .req_wdata(32'hCAFE0015), .req_ready(a15_ready),
        .rsp_valid(a15_valid), .rsp_rdata(a15_rdata), .rsp_err(a15_err), .state(a15_state)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at %0t: wait bound expired", nm, $time);
    endtask

    // Reference model: a request occupies the memory from its acceptance edge until one
    // cycle after the response edge, which lies exactly LAT clock periods after acceptance.
    logic [31:0] ref_mem [DEPTH];
    bit          known [DEPTH];
    bit          m_pend, m_valid, m_err, m_rknown;
    logic [31:0] m_rdata;
    time         m_due;
    bit          p_we, p_err;
    int          p_idx;
    logic [31:0] p_wdata;
    time         acc_q[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend = 0; m_valid = 0; m_err = 0; m_rdata = 32'h0; m_rknown = 1;
        end else begin
            automatic bit was_idle = !m_pend && !m_valid;
            m_valid = 0;
            if (m_pend && $time == m_due) begin
                m_pend = 0; m_valid = 1; m_err = p_err; m_rdata = 32'h0; m_rknown = 1;
                if (!p_err && p_we) begin
                    ref_mem[p_idx] = p_wdata;
                    known[p_idx] = 1;
                end else if (!p_err) begin
                    m_rdata = ref_mem[p_idx];
                    m_rknown = known[p_idx];
                end
            end else if (was_idle && req_valid) begin
                p_we = req_we;
                p_wdata = req_wdata;
                p_err = (req_addr % 4 != 0) || (req_addr / 4 >= DEPTH);
                p_idx = int'(req_addr / 4);
                m_pend = 1;
                m_due = $time + LAT * PERIOD;
                acc_q.push_back($time);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("req_ready", 32'(req_ready), 32'(!m_pend && !m_valid));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
            chk("state", 32'(state), m_valid ? 32'd2 : (m_pend ? 32'd1 : 32'd0));
            if (m_rknown) chk("rsp_rdata", rsp_rdata, m_rdata);
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) timeout("wait_ready");
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic er, output time tr);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) timeout("wait_rsp");
        tr = $time; rd = rsp_rdata; er = rsp_err;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output time ta,
                          output time tr);
        @(posedge clk);
        #1;
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd;
        wait_ready();
        @(posedge clk);
        ta = $time;
        #1;
        req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom);
        wait_rsp(rd, er, tr);
    endtask

    initial begin
        logic [31:0] rd, rd2, a;
        logic        er;
        time         ta, tr, t1, t2;

        #200000;
        $display("FAIL watchdog at %0t: simulation did not complete", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rd2, a;
        logic        er;
        time         ta, tr, t1, t2;

        // Reset with a request pending on the bus: nothing may be accepted.
        #2;
        reset = 0;
        chk_on = 1;
        req_valid = 1; req_addr = 32'h10; req_we = 1;
        repeat (3) begin
            @(negedge clk);
            chk("reset ready", 32'(req_ready), 32'd1);
            chk("reset state", 32'(state), 32'd0);
            chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        req_valid = 0;
        reset = 1;
        chk("no accept in reset", 32'(acc_q.size()), 32'd0);

        // Fill memory so every later read has a known value.
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0:       a = 32'hA5A50000;
                1:       a = 32'h11111111;
                2:       a = 32'h22222222;
                8:       a = 32'h0;
                default: a = $urandom;
            endcase
            do_req(1, 32'(i * 4), a, rd, er, ta, tr);
        end

        do_req(1, 32'h10, 32'hDEADBEEF, rd, er, ta, tr);
        chk("wr latency", 32'(tr - ta), 32'(LAT * PERIOD + PERIOD / 2));
        chk("wr err", 32'(er), 32'd0);
        chk("wr rdata", rd, 32'h0);
        do_req(0, 32'h10, 32'h0, rd, er, ta, tr);
        chk("raw rdata", rd, 32'hDEADBEEF);

        do_req(0, 32'h12, 32'h0, rd, er, ta, tr);
        chk("misaligned err", 32'(er), 32'd1);
        chk("misaligned rdata", rd, 32'h0);
        do_req(1, 32'h100, 32'h1234, rd, er, ta, tr);
        chk("oor err", 32'(er), 32'd1);
        do_req(0, 32'h0, 32'h0, rd, er, ta, tr);
        chk("oor no write", rd, 32'hA5A50000);

        // Back-to-back with req_valid held high throughout.
        @(posedge clk);
        #1;
        req_valid = 1; req_we = 0; req_addr = 32'h4;
        wait_ready();
        @(posedge clk);
        t1 = $time;
        #1;
        req_addr = 32'h8;
        wait_rsp(rd, er, tr);
        wait_ready();
        @(posedge clk);
        t2 = $time;
        #1;
        req_valid = 0;
        wait_rsp(rd2, er, tr);
        chk("b2b spacing", 32'(t2 - t1), 32'((LAT + 2) * PERIOD));
        chk("b2b first", rd, 32'h11111111);
        chk("b2b second", rd2, 32'h22222222);

        // Reset one edge after accepting a write: the write must be lost.
        @(posedge clk);
        #1;
        req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'h55AA55AA;
        wait_ready();
        @(posedge clk);
        #1;
        req_valid = 0;
        @(posedge clk);
        #1;
        reset = 0;
        #1;
        chk("midwait state", 32'(state), 32'd0);
        chk("midwait rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midwait ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        do_req(0, 32'h20, 32'h0, rd, er, ta, tr);
        chk("midwait discarded", rd, 32'h0);

        // Randomized traffic with occasional mid-flight resets.
        for (int it = 0; it < 200; it++) begin
            automatic int kind = int'($urandom_range(0, 11));
            case (kind)
                8:       a = {$urandom_range(0, DEPTH - 1), 2'b00} | 32'($urandom_range(1, 3));
                9:       a = {$urandom_range(DEPTH, 32'h3FFF_FFFF), 2'b00};
                default: a = {24'h0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
            endcase
            if (kind == 10) begin
                @(posedge clk);
                #1;
                req_valid = 1; req_we = 1; req_addr = a; req_wdata = $urandom;
                wait_ready();
                @(posedge clk);
                #1;
                req_valid = 0;
                repeat ($urandom_range(0, LAT)) @(posedge clk);
                #1;
                reset = 0;
                @(posedge clk);
                #1;
                reset = 1;
            end else begin
                do_req(1'($urandom), a, $urandom, rd, er, ta, tr);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // LATENCY=1 and LATENCY=15 builds accept the same write at one edge.
        @(posedge clk);
        #1;
        x_valid = 1; x_addr = 32'h0;
        @(negedge clk);
        chk("l1 ready", 32'(a1_ready), 32'd1);
        chk("l15 ready", 32'(a15_ready), 32'd1);
        @(posedge clk);
        #1;
        x_valid = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk("l1 pulse", 32'(a1_valid), 32'(i == 1));
            chk("l15 pulse", 32'(a15_valid), 32'(i == 15));
            chk("l1 state", 32'(a1_state), (i == 0) ? 32'd1 : ((i == 1) ? 32'd2 : 32'd0));
            chk("l15 state", 32'(a15_state), (i < 15) ? 32'd1 : ((i == 15) ? 32'd2 : 32'd0));
            if (i == 1) begin
                chk("l1 err", 32'(a1_err), 32'd0);
                chk("l1 rdata", a1_rdata, 32'h0);
            end
            if (i == 15) begin
                chk("l15 err", 32'(a15_err), 32'd0);
                chk("l15 rdata", a15_rdata, 32'h0);
            end
        end

        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
